fp_addsub_p: RTL and testbench

- Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor. It is the next-generation replacement for the single-precision adder in the FP arithmetic library.
- Adds over the previous adder:
  - configurable exponent/mantissa widths
  - runtime add/sub select
  - full leading-zero normalisation
  - round-to-nearest-even
  - special-value handling
  - valid/ready backpressure
- Sits between operand-fetch logic and downstream FP consumers (accumulators, MAC datapaths).

---
 rtl/fp_addsub_p.sv | 241 ++++++++++++++++++++++++
 tb/tb_fp_addsub_p.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_p.sv
// rtl/fp_addsub_p.sv - 5-stage pipelined floating-point adder/subtractor with valid/ready
// Optional macro FP_ADDSUB_FLAGS_EN adds the registered flags[3:0] = {invalid, overflow, underflow, inexact} port.
module fp_addsub_p #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] sum
`ifdef FP_ADDSUB_FLAGS_EN
  ,
  output logic [3:0]   flags
`endif
);

  localparam int FW = MAN_W + 4;
  localparam int SW = $clog2(FW + 1);
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] X_ONE  = XW'(1);
  localparam logic signed [XW-1:0] X_ZERO = '0;
  localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic stall, en;
  logic v1, v2, v3, v4, v5;

  assign stall   = v5 && !out_rdy;
  assign en      = !stall;
  assign in_rdy  = en;
  assign out_vld = v5;

  // ---------------- stage 1: unpack, classify, swap
  logic                   sa, sb;
  logic [EXP_W-1:0]       ea, eb, e_big, e_sml, d_raw;
  logic [MAN_W-1:0]       ma, mb;
  logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, nan_res, swap, s_big;
  logic [EXP_W+MAN_W-1:0] a_mag, b_mag;
  logic [FW-1:0]          x_big, x_sml;
  logic [SW-1:0]          d_n;
  logic [W-1:0]           spec_val_n;

  always_comb begin
    sa = a[W-1];
    ea = a[W-2:MAN_W];
    ma = a[MAN_W-1:0];
    sb = b[W-1] ^ op_sub;
    eb = b[W-2:MAN_W];
    mb = b[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (ma == '0);
    b_inf  = (eb == '1) && (mb == '0);
    a_nan  = (ea == '1) && (ma != '0);
    b_nan  = (eb == '1) && (mb != '0);
    // subnormals flush to zero before the magnitude compare
    a_mag  = a_zero ? '0 : {ea, ma};
    b_mag  = b_zero ? '0 : {eb, mb};
    swap   = (b_mag > a_mag);
    s_big  = swap ? sb : sa;
    e_big  = swap ? eb : ea;
    e_sml  = swap ? ea : eb;
    x_big  = swap ? {!b_zero, b_mag[MAN_W-1:0], 3'b000} : {!a_zero, a_mag[MAN_W-1:0], 3'b000};
    x_sml  = swap ? {!a_zero, a_mag[MAN_W-1:0], 3'b000} : {!b_zero, b_mag[MAN_W-1:0], 3'b000};
    d_raw  = e_big - e_sml;
    d_n    = (32'(d_raw) >= FW) ? SW'(FW) : SW'(d_raw);
    nan_res = a_nan || b_nan || (a_inf && b_inf && (sa ^ sb));
    spec_val_n = nan_res ? QNAN :
                 a_inf   ? {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                           {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  logic             sgn1, sub1, zs1, spec1;
  logic [EXP_W-1:0] exp1;
  logic [FW-1:0]    big1, sml1;
  logic [SW-1:0]    d1;
  logic [W-1:0]     sv1;

  // ---------------- stage 2: align small operand with sticky collection
  logic [2*FW-1:0] wide;
  logic [FW-1:0]   al_n;

  always_comb begin
    wide = {sml1, {FW{1'b0}}} >> d1;
    al_n = wide[2*FW-1:FW];
    al_n[0] = al_n[0] | (|wide[FW-1:0]);
  end

  logic             sgn2, sub2, zs2, spec2;
  logic [EXP_W-1:0] exp2;
  logic [FW-1:0]    big2, sml2;
  logic [W-1:0]     sv2;

  // ---------------- stage 3: add/sub, never negative thanks to the swap
  logic [FW:0] mag_n;

  always_comb begin
    mag_n = sub2 ? ({1'b0, big2} - {1'b0, sml2}) : ({1'b0, big2} + {1'b0, sml2});
  end

  logic             sgn3, zs3, spec3;
  logic [EXP_W-1:0] exp3;
  logic [FW:0]      mag3;
  logic [W-1:0]     sv3;

  // ---------------- stage 4: normalise
  logic [SW-1:0]          lzc;
  logic [FW-1:0]          norm_n;
  logic signed [XW-1:0]   e4_n;
  logic                   zero_n;

  always_comb begin
    lzc = SW'(FW);
    for (int i = FW - 1; i >= 0; i--) begin
      if (lzc == SW'(FW) && mag3[i]) lzc = SW'(FW - 1 - i);
    end
    zero_n = (mag3 == '0);
    if (mag3[FW]) begin
      norm_n = {mag3[FW:2], mag3[1] | mag3[0]};
      e4_n   = $signed({2'b00, exp3}) + X_ONE;
    end else begin
      norm_n = mag3[FW-1:0] << lzc;
      e4_n   = $signed({2'b00, exp3}) - $signed(XW'(lzc));
    end
  end

  logic                 sgn4, zs4, spec4, zero4;
  logic signed [XW-1:0] e4;
  logic [FW-1:0]        norm4;
  logic [W-1:0]         sv4;

  // ---------------- stage 5: round to nearest even, range check, pack
  logic                 g5, r5, s5, inc, ovf, unf;
  logic [MAN_W+1:0]     rnd;
  logic [MAN_W-1:0]     man5;
  logic signed [XW-1:0] e5;
  logic [W-1:0]         res_n;

  always_comb begin
    g5   = norm4[2];
    r5   = norm4[1];
    s5   = norm4[0];
    inc  = g5 && (r5 || s5 || norm4[3]);
    rnd  = {1'b0, norm4[FW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    e5   = rnd[MAN_W+1] ? (e4 + X_ONE) : e4;
    man5 = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    ovf  = !zero4 && (e5 >= EMAX_X);
    unf  = !zero4 && (e5 <= X_ZERO);
    if (spec4)      res_n = sv4;
    else if (zero4) res_n = {zs4, {(W-1){1'b0}}};
    else if (ovf)   res_n = {sgn4, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (unf)   res_n = {sgn4, {(W-1){1'b0}}};
    else            res_n = {sgn4, e5[EXP_W-1:0], man5};
  end

  // ---------------- pipeline registers: single enable, no bubble compaction
  always_ff @(posedge clk) begin
    if (rst) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      v4  <= 1'b0;
      v5  <= 1'b0;
      sum <= '0;
    end else if (en) begin
      v1 <= in_vld;
      v2 <= v1;
      v3 <= v2;
      v4 <= v3;
      v5 <= v4;
      if (v4) sum <= res_n;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      sgn1  <= s_big;
      sub1  <= sa ^ sb;
      zs1   <= sa & sb;
      spec1 <= nan_res || a_inf || b_inf;
      exp1  <= e_big;
      big1  <= x_big;
      sml1  <= x_sml;
      d1    <= d_n;
      sv1   <= spec_val_n;

      sgn2  <= sgn1;
      sub2  <= sub1;
      zs2   <= zs1;
      spec2 <= spec1;
      exp2  <= exp1;
      big2  <= big1;
      sml2  <= al_n;
      sv2   <= sv1;

      sgn3  <= sgn2;
      zs3   <= zs2;
      spec3 <= spec2;
      exp3  <= exp2;
      mag3  <= mag_n;
      sv3   <= sv2;

      sgn4  <= sgn3;
      zs4   <= zs3;
      spec4 <= spec3;
      zero4 <= zero_n;
      e4    <= e4_n;
      norm4 <= norm_n;
      sv4   <= sv3;
    end
  end

`ifdef FP_ADDSUB_FLAGS_EN
  logic inv1, inv2, inv3, inv4;

  always_ff @(posedge clk) begin
    if (en) begin
      inv1 <= nan_res;
      inv2 <= inv1;
      inv3 <= inv2;
      inv4 <= inv3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= 4'b0000;
    end else if (en && v4) begin
      flags <= {inv4, ovf && !spec4, unf && !spec4, (g5 || r5 || s5 || ovf || unf) && !spec4};
    end
  end
`endif

endmodule

// File: tb/tb_fp_addsub_p.sv
// tb/tb_fp_addsub_p.sv - directed table and streaming checks for fp_addsub_p (FP32)
// Flag checks compile in when FP_ADDSUB_FLAGS_EN is defined.
module tb_fp_addsub_p;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_vld = 1'b0;
  logic        op_sub = 1'b0;
  logic        out_rdy = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_rdy, out_vld;
  logic [31:0] sum;
`ifdef FP_ADDSUB_FLAGS_EN
  logic [3:0]  flags;
`endif

  fp_addsub_p #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .op_sub(op_sub),
    .a(a), .b(b), .out_vld(out_vld), .out_rdy(out_rdy), .sum(sum)
`ifdef FP_ADDSUB_FLAGS_EN
    , .flags(flags)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, req);
    end
  endtask

  task automatic set_vec(input int i, input string n, input logic [31:0] va, input logic [31:0] vb,
                         input logic vo, input logic [31:0] vr, input logic [3:0] vf);
    vecs[i].name = n; vecs[i].a = va; vecs[i].b = vb;
    vecs[i].op = vo; vecs[i].res = vr; vecs[i].fl = vf;
  endtask

  // exact small integers converted through the double encoding
  function automatic logic [31:0] to_f32(input int x);
    real         r;
    logic [63:0] d;
    logic [10:0] e;
    if (x == 0) return 32'h0;
    r = real'(x);
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  task automatic run_one(input int i);
    @(posedge clk); #1;
    in_vld = 1'b1; a = vecs[i].a; b = vecs[i].b; op_sub = vecs[i].op;
    @(posedge clk); #1;
    in_vld = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({vecs[i].name, "_lat4_vld"}, {31'b0, out_vld}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({vecs[i].name, "_lat5_vld"}, {31'b0, out_vld}, 32'd1);
    check({vecs[i].name, "_sum"}, sum, vecs[i].res);
`ifdef FP_ADDSUB_FLAGS_EN
    check({vecs[i].name, "_flags"}, {28'b0, flags}, {28'b0, vecs[i].fl});
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  int          sa_i[20], sb_i[20];
  logic        op_i[20];
  logic [31:0] exp_q[$];
  logic [31:0] prev_sum;
  logic        prev_stall;
  logic        seen_vld;
  int          sent, recv;

  initial begin
    set_vec(0,  "add_1_2",      32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    set_vec(1,  "sub_3_1",      32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
    set_vec(2,  "cancel_lzc",   32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'b0000);
    set_vec(3,  "carry_tie",    32'h3F800001, 32'h3F800000, 1'b0, 32'h40000000, 4'b0001);
    set_vec(4,  "rne_tie_even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    set_vec(5,  "rne_tie_up",   32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
    set_vec(6,  "rne_sticky",   32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001);
    set_vec(7,  "inf_p_ninf",   32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
    set_vec(8,  "overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    set_vec(9,  "nan_in",       32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
    set_vec(10, "nzero_nzero",  32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    set_vec(11, "subnorm",      32'h00400000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000);
    set_vec(12, "x_minus_x",    32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    set_vec(13, "pzero_nzero",  32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000);
    set_vec(14, "ninf_sub_fin", 32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 4'b0000);
    set_vec(15, "underflow",    32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
    set_vec(16, "inf_sub_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
    set_vec(17, "sub_lzc2",     32'h40000000, 32'h3F800001, 1'b1, 32'h3F7FFFFE, 4'b0000);
    set_vec(18, "neg_result",   32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_vld", {31'b0, out_vld}, 32'd0);
    check("reset_in_rdy", {31'b0, in_rdy}, 32'd1);
    check("reset_sum", sum, 32'h0);
`ifdef FP_ADDSUB_FLAGS_EN
    check("reset_flags", {28'b0, flags}, 32'd0);
`endif

    for (int i = 0; i < 19; i++) run_one(i);

    // streaming with random backpressure against a scoreboard
    for (int i = 0; i < 20; i++) begin
      sa_i[i] = int'($urandom_range(0, 2000)) - 1000;
      sb_i[i] = int'($urandom_range(0, 2000)) - 1000;
      op_i[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; recv = 0; prev_stall = 1'b0; prev_sum = '0;
    @(posedge clk); #1;
    in_vld = 1'b1; a = to_f32(sa_i[0]); b = to_f32(sb_i[0]); op_sub = op_i[0];
    for (int cyc = 0; cyc < 400 && recv < 20; cyc++) begin
      @(negedge clk);
      check("in_rdy_rule", {31'b0, in_rdy}, {31'b0, !(out_vld && !out_rdy)});
      if (prev_stall) begin
        check("stall_hold_vld", {31'b0, out_vld}, 32'd1);
        check("stall_hold_sum", sum, prev_sum);
      end
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) check("stream_extra", sum, 32'hDEADBEEF);
        else check("stream_sum", sum, exp_q.pop_front());
        recv++;
      end
      if (in_vld && in_rdy) begin
        exp_q.push_back(to_f32(op_i[sent] ? (sa_i[sent] - sb_i[sent]) : (sa_i[sent] + sb_i[sent])));
        sent++;
      end
      prev_stall = out_vld && !out_rdy;
      prev_sum = sum;
      @(posedge clk); #1;
      out_rdy = ($urandom_range(0, 2) != 0);
      if (sent < 20) begin
        in_vld = 1'b1; a = to_f32(sa_i[sent]); b = to_f32(sb_i[sent]); op_sub = op_i[sent];
      end else begin
        in_vld = 1'b0;
      end
    end
    check("stream_recv_count", recv, 32'd20);
    out_rdy = 1'b1;
    in_vld = 1'b0;
    seen_vld = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen_vld = seen_vld | out_vld;
    end
    check("stream_no_dup", {31'b0, seen_vld}, 32'd0);

    // reset with four operations in flight
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_vld = 1'b1; a = vecs[i].a; b = vecs[i].b; op_sub = vecs[i].op;
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_vld", {31'b0, out_vld}, 32'd0);
    seen_vld = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen_vld = seen_vld | out_vld;
    end
    check("midrst_no_stale", {31'b0, seen_vld}, 32'd0);
    run_one(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
